// File: rtl/aes_result_collector.sv
// ---------------------------------------------------------------------------
// aes_result_collector
//
// Collects ciphertext blocks from NUM_AES AES cores and releases them in
// strict core order 0,1,...,NUM_AES-1,0,... It is the counterpart of the
// round-robin block dispatcher. Each core has one 128-bit holding slot with
// a full flag. A one-hot read pointer selects the next slot to release into
// a single registered output stage, which uses a valid/ready handshake.
//
// Parameters
//   NUM_AES     number of attached AES cores (must be >= 2)
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   core_done   per-core one-cycle strobe; result valid on ecb_out slice i
//   ecb_out     core results; core i drives bits [128*i+127:128*i]
//   flush       synchronous clear of slots, output stage and pointer
//   data_ready  downstream accepts data_out this cycle
//   data_valid  data_out holds a valid block
//   data_out    in-order ciphertext block (holds last value when not valid)
//   pending     bit i = slot i holds an unreleased result
//   overrun     sticky flag: a result arrived while its slot was still full
//
// Optional feature
//   AES_COLLECT_OVERRUN_CHK_EN  when defined, builds the sticky overrun
//   detector. When undefined, overrun is tied 0. In both builds a result
//   that arrives at a full, non-draining slot is dropped.
//
// Output stage FSM
//   state | meaning
//   EMPTY | data_valid=0, data_out keeps its last value
//   HOLD  | data_valid=1, data_out stable until data_ready
// ---------------------------------------------------------------------------
module aes_result_collector #(
    parameter int NUM_AES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_AES-1:0]     core_done,
    input  logic [128*NUM_AES-1:0] ecb_out,
    input  logic                   flush,
    input  logic                   data_ready,
    output logic                   data_valid,
    output logic [127:0]           data_out,
    output logic [NUM_AES-1:0]     pending,
    output logic                   overrun
);

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             state;
    logic [127:0]       slot_data [NUM_AES];
    logic [NUM_AES-1:0] slot_full;
    logic [NUM_AES-1:0] rd_ptr;
    logic [NUM_AES-1:0] drain;
    logic [NUM_AES-1:0] accept;
    logic [127:0]       sel_data;
    logic               sel_full;
    logic               xfer;

    // rd_ptr is one-hot, so a plain priority loop acts as a mux.
    always_comb begin
        sel_data = '0;
        sel_full = 1'b0;
        for (int i = 0; i < NUM_AES; i++) begin
            if (rd_ptr[i]) begin
                sel_data = slot_data[i];
                sel_full = slot_full[i];
            end
        end
    end

    assign xfer   = sel_full && ((state == EMPTY) || data_ready);
    assign drain  = rd_ptr & {NUM_AES{xfer}};
    // A slot that is being drained on this edge may be refilled on the same edge.
    assign accept = core_done & (~slot_full | drain);

    assign pending = slot_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_AES; i++) begin
                slot_data[i] <= '0;
            end
            slot_full <= '0;
        end else if (flush) begin
            slot_full <= '0;
        end else begin
            for (int i = 0; i < NUM_AES; i++) begin
                if (accept[i]) begin
                    slot_data[i] <= ecb_out[128*i +: 128];
                end
            end
            slot_full <= (slot_full & ~drain) | accept;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            data_valid <= 1'b0;
            data_out   <= '0;
            rd_ptr     <= NUM_AES'(1);
        end else if (flush) begin
            state      <= EMPTY;
            data_valid <= 1'b0;
            data_out   <= '0;
            rd_ptr     <= NUM_AES'(1);
        end else begin
            case (state)
                EMPTY: begin
                    if (xfer) begin
                        state      <= HOLD;
                        data_valid <= 1'b1;
                        data_out   <= sel_data;
                        rd_ptr     <= {rd_ptr[NUM_AES-2:0], rd_ptr[NUM_AES-1]};
                    end
                end
                HOLD: begin
                    if (xfer) begin
                        data_out <= sel_data;
                        rd_ptr   <= {rd_ptr[NUM_AES-2:0], rd_ptr[NUM_AES-1]};
                    end else if (data_ready) begin
                        state      <= EMPTY;
                        data_valid <= 1'b0;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    data_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef AES_COLLECT_OVERRUN_CHK_EN
    logic [NUM_AES-1:0] drop;

    assign drop = core_done & slot_full & ~drain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (flush) begin
            overrun <= 1'b0;
        end else if (|drop) begin
            overrun <= 1'b1;
        end
    end
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_aes_result_collector.sv
module tb_aes_result_collector;

    localparam int NUM_AES = 3;
`ifdef AES_COLLECT_OVERRUN_CHK_EN
    localparam logic OVR_ON = 1'b1;
`else
    localparam logic OVR_ON = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NUM_AES-1:0]     core_done;
    logic [128*NUM_AES-1:0] ecb_out;
    logic                   flush;
    logic                   data_ready;
    logic                   data_valid;
    logic [127:0]           data_out;
    logic [NUM_AES-1:0]     pending;
    logic                   overrun;

    aes_result_collector #(.NUM_AES(NUM_AES)) dut (
        .clk        (clk),
        .rst        (rst),
        .core_done  (core_done),
        .ecb_out    (ecb_out),
        .flush      (flush),
        .data_ready (data_ready),
        .data_valid (data_valid),
        .data_out   (data_out),
        .pending    (pending),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] done;
        logic [7:0] t0;
        logic [7:0] t1;
        logic [7:0] t2;
        logic       fl;
        logic       rdy;
        logic       ev;
        logic [7:0] et;
        logic       cd;
        logic [2:0] ep;
        logic       eo;
    } vec_t;

    localparam int NV = 39;
    vec_t vecs [NV];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cur   = -1;

    function automatic logic [127:0] blk(input logic [7:0] t);
        return {16{t}};
    endfunction

    function automatic vec_t mk(input logic [2:0] d, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] c, input logic f, input logic r, input logic ev,
                                input logic [7:0] et, input logic cd, input logic [2:0] ep,
                                input logic eo);
        vec_t v;
        v.done = d; v.t0 = a; v.t1 = b; v.t2 = c; v.fl = f; v.rdy = r;
        v.ev = ev; v.et = et; v.cd = cd; v.ep = ep; v.eo = eo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h expected %h", name, cur, act, exp);
        end
    endtask

    initial begin
        //            done    t0     t1     t2    fl  rdy  ev  et     cd  ep      eo
        // in-order A,B,C
        vecs[0]  = mk(3'b001, 8'hA1, 8'h00, 8'h00, 0, 1, 0, 8'h00, 1, 3'b001, 0);
        vecs[1]  = mk(3'b010, 8'h00, 8'hB2, 8'h00, 0, 1, 1, 8'hA1, 1, 3'b010, 0);
        vecs[2]  = mk(3'b100, 8'h00, 8'h00, 8'hC3, 0, 1, 1, 8'hB2, 1, 3'b100, 0);
        vecs[3]  = mk(3'b000, 8'h00, 8'h00, 8'h00, 0, 1, 1, 8'hC3, 1, 3'b000, 0);
        vecs[4]  = mk(3'b000, 8'h00, 8'h00, 8'h00, 0, 1, 0, 8'hC3, 1, 3'b000, 0);
        // out-of-order C,B,A
        vecs[5]  = mk(3'b100, 8'h00, 8'h00, 8'h33, 0, 1, 0, 8'hC3, 1, 3'b100, 0);
        vecs[6]  = mk(3'b010, 8'h00, 8'h22, 8'h00, 0, 1, 0, 8'hC3, 1, 3'b110, 0);
        vecs[7]  = mk(3'b001, 8'h11, 8'h00, 8'h00, 0, 1, 0, 8'hC3, 1, 3'b111, 0);
        vecs[8]  = mk(3'b000, 8'h00, 8'h00, 8'h00, 0, 1, 1, 8'h11, 1, 3'b110, 0);
        vecs[9]  = mk(3'b000, 8'h00, 8'h00, 8'h00, 0, 1, 1, 8'h22, 1, 3'b100, 0);
        vecs[10] = mk(3'b000, 8'h00, 8'h00, 8'h00, 0, 1, 1, 8'h33, 1, 3'b000, 0);
        vecs[11] = mk(3'b000, 8'h00, 8'h00, 8'h00, 0, 1, 0, 8'h33, 1, 3'b000, 0);
        // backpressure
        vecs[12] = mk(3'b011, 8'h44, 8'h55, 8'h00, 0, 0, 0, 8'h33, 1, 3'b011, 0);
        vecs[13] = mk(3'b000, 8'h00, 8'h00, 8'h00, 0, 0, 1, 8'h44, 1, 3'b010, 0);
        vecs[14] = mk(3'b000, 8'h00, 8'h00, 8'h00, 0, 0, 1, 8'h44, 1, 3'b010, 0);
        vecs[15] = mk(3'b000, 8'h00, 8'h00, 8'h00, 0, 0, 1, 8'h44, 1, 3'b010, 0);
        vecs[16] = mk(3'b000, 8'h00, 8'h00, 8'h00, 0, 0, 1, 8'h44, 1, 3'b010, 0);
        vecs[17] = mk(3'b000, 8'h00, 8'h00, 8'h00, 0, 0, 1, 8'h44, 1, 3'b010, 0);
        vecs[18] = mk(3'b000, 8'h00, 8'h00, 8'h00, 0, 0, 1, 8'h44, 1, 3'b010, 0);
        vecs[19] = mk(3'b000, 8'h00, 8'h00, 8'h00, 0, 1, 1, 8'h55, 1, 3'b000, 0);
        vecs[20] = mk(3'b000, 8'h00, 8'h00, 8'h00, 0, 1, 0, 8'h55, 1, 3'b000, 0);
        // drain and refill slot 2, then no skipping past empty slot 0
        vecs[21] = mk(3'b100, 8'h00, 8'h00, 8'h66, 0, 0, 0, 8'h55, 1, 3'b100, 0);
        vecs[22] = mk(3'b100, 8'h00, 8'h00, 8'h77, 0, 0, 1, 8'h66, 1, 3'b100, 0);
        vecs[23] = mk(3'b000, 8'h00, 8'h00, 8'h00, 0, 1, 0, 8'h66, 1, 3'b100, 0);
        vecs[24] = mk(3'b001, 8'h88, 8'h00, 8'h00, 0, 1, 0, 8'h66, 1, 3'b101, 0);
        vecs[25] = mk(3'b000, 8'h00, 8'h00, 8'h00, 0, 1, 1, 8'h88, 1, 3'b100, 0);
        vecs[26] = mk(3'b000, 8'h00, 8'h00, 8'h00, 0, 1, 0, 8'h88, 1, 3'b100, 0);
        // flush overrides a strobe, then overrun on slot 1
        vecs[27] = mk(3'b001, 8'h99, 8'h00, 8'h00, 1, 1, 0, 8'h00, 0, 3'b000, 0);
        vecs[28] = mk(3'b010, 8'h00, 8'hB5, 8'h00, 0, 1, 0, 8'h00, 0, 3'b010, 0);
        vecs[29] = mk(3'b010, 8'h00, 8'hD4, 8'h00, 0, 1, 0, 8'h00, 0, 3'b010, 1);
        vecs[30] = mk(3'b001, 8'hA5, 8'h00, 8'h00, 0, 1, 0, 8'h00, 0, 3'b011, 1);
        vecs[31] = mk(3'b000, 8'h00, 8'h00, 8'h00, 0, 1, 1, 8'hA5, 1, 3'b010, 1);
        vecs[32] = mk(3'b000, 8'h00, 8'h00, 8'h00, 0, 1, 1, 8'hB5, 1, 3'b000, 1);
        vecs[33] = mk(3'b000, 8'h00, 8'h00, 8'h00, 1, 1, 0, 8'h00, 0, 3'b000, 0);
        // four blocks, pointer wraps back to core 0
        vecs[34] = mk(3'b001, 8'hE0, 8'h00, 8'h00, 0, 1, 0, 8'h00, 0, 3'b001, 0);
        vecs[35] = mk(3'b010, 8'h00, 8'hE1, 8'h00, 0, 1, 1, 8'hE0, 1, 3'b010, 0);
        vecs[36] = mk(3'b100, 8'h00, 8'h00, 8'hE2, 0, 1, 1, 8'hE1, 1, 3'b100, 0);
        vecs[37] = mk(3'b001, 8'hE3, 8'h00, 8'h00, 0, 1, 1, 8'hE2, 1, 3'b001, 0);
        vecs[38] = mk(3'b000, 8'h00, 8'h00, 8'h00, 0, 1, 1, 8'hE3, 1, 3'b000, 0);

        rst        = 1'b1;
        core_done  = '0;
        ecb_out    = '0;
        flush      = 1'b0;
        data_ready = 1'b0;
        #3;
        chk("reset_valid",   128'(data_valid), 128'(1'b0));
        chk("reset_data",    data_out, '0);
        chk("reset_pending", 128'(pending), 128'(3'b000));
        chk("reset_overrun", 128'(overrun), 128'(1'b0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            core_done  = vecs[k].done;
            ecb_out    = {blk(vecs[k].t2), blk(vecs[k].t1), blk(vecs[k].t0)};
            flush      = vecs[k].fl;
            data_ready = vecs[k].rdy;
            @(posedge clk);
            #1;
            cur = k;
            chk("valid",   128'(data_valid), 128'(vecs[k].ev));
            chk("pending", 128'(pending), 128'(vecs[k].ep));
            chk("overrun", 128'(overrun), 128'(vecs[k].eo & OVR_ON));
            if (vecs[k].cd) chk("data", data_out, blk(vecs[k].et));
        end

        // asynchronous reset while a block is held
        cur = 100;
        @(negedge clk);
        core_done  = '0;
        ecb_out    = '0;
        flush      = 1'b0;
        data_ready = 1'b0;
        chk("pre_rst_valid", 128'(data_valid), 128'(1'b1));
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid",   128'(data_valid), 128'(1'b0));
        chk("async_rst_data",    data_out, '0);
        chk("async_rst_pending", 128'(pending), 128'(3'b000));
        chk("async_rst_overrun", 128'(overrun), 128'(1'b0));

        // the first edge after release already captures a strobe
        cur = 101;
        @(negedge clk);
        rst        = 1'b0;
        core_done  = 3'b001;
        ecb_out    = {blk(8'h00), blk(8'h00), blk(8'hF0)};
        data_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_pending", 128'(pending), 128'(3'b001));
        chk("post_rst_valid",   128'(data_valid), 128'(1'b0));
        chk("post_rst_data",    data_out, '0);
        cur = 102;
        @(negedge clk);
        core_done = '0;
        ecb_out   = '0;
        @(posedge clk);
        #1;
        chk("post_rst_out_valid", 128'(data_valid), 128'(1'b1));
        chk("post_rst_out_data",  data_out, blk(8'hF0));
        chk("post_rst_out_pend",  128'(pending), 128'(3'b000));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_result_collector.md
AES_RESULT_COLLECTOR -- requirements
Module: aes_result_collector

Interface
REQ-001 Parameter NUM_AES, default 3: number of attached AES cores; SHALL be >= 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 core_done  input  NUM_AES  per-core one-cycle strobe; result valid on ecb_out slice i.
REQ-005 ecb_out  input  128*NUM_AES  core results; core i occupies bits [128*i+127:128*i].
REQ-006 flush  input  1  synchronous clear of all slots, output stage and pointer.
REQ-007 data_ready  input  1  downstream accepts data_out this cycle.
REQ-008 data_valid  output  1  data_out holds a valid block.
REQ-009 data_out  output  128  in-order ciphertext block.
REQ-010 pending  output  NUM_AES  slot-full flags, bit i = slot i holds an unreleased result.
REQ-011 overrun  output  1  sticky error flag; see Configuration.

Function
REQ-012 Counterpart of the round-robin block dispatcher: SHALL release results strictly in core order 0,1,...,NUM_AES-1,0,...
REQ-013 One 128-bit holding slot plus full flag per core; core_done[i] with slot i empty SHALL capture slice i and set pending[i] at that edge.
REQ-014 Read pointer SHALL be a one-hot ring of NUM_AES bits, reset to bit 0, wrapping from bit NUM_AES-1 to bit 0.
REQ-015 Output stage FSM states: EMPTY (data_valid=0), HOLD (data_valid=1).
REQ-016 Transfer condition: slot at read pointer full AND (state EMPTY OR (HOLD AND data_ready)).
REQ-017 On transfer: data_out loads the slot, slot flag clears, pointer advances one position, state becomes or stays HOLD.
REQ-018 HOLD with data_ready=1 and no transfer SHALL go to EMPTY; HOLD with data_ready=0 SHALL hold data_out stable.
REQ-019 Latency: core_done at edge N with output stage EMPTY and slot at pointer -> data_valid=1 after edge N+1.
REQ-020 Throughput: one block per cycle while slots at successive pointer positions are full and data_ready=1.
REQ-021 Out-of-order completion: a full slot not at the pointer SHALL wait; no skipping.
REQ-022 core_done[i] on the same edge slot i is transferred SHALL be accepted (drain and refill); pending[i] stays 1.
REQ-023 core_done[i] while slot i full and not draining SHALL drop the new data; slot contents are unchanged.
REQ-024 flush SHALL clear all pending bits, return the FSM to EMPTY and the pointer to bit 0, and override core_done on the same edge.
REQ-025 data_out SHALL hold its last value when data_valid=0.

Reset
REQ-026 rst=1 SHALL immediately force pending=0, data_valid=0, data_out=0, overrun=0, pointer=bit 0, FSM=EMPTY.
REQ-027 rst asserted mid-transfer SHALL discard all held results; no partial block SHALL appear after release.
REQ-028 First edge after rst deasserts SHALL already sample core_done.

Configuration
REQ-029 Macro AES_COLLECT_OVERRUN_CHK_EN defined: overrun SHALL set on any REQ-023 event and remain 1 until rst or flush.
REQ-030 Macro undefined: overrun SHALL be tied 0 and no detection logic SHALL be present; REQ-023 drop behaviour is unchanged.

Verification (NUM_AES=3)
REQ-031 In-order: core_done 0,1,2 on consecutive cycles with data A,B,C and data_ready=1 -> data_out A,B,C on 3 consecutive cycles, starting 2 edges after the first strobe.
REQ-032 Out-of-order: core 2 done (C), then 1 (B), then 0 (A) -> no data_valid until A arrives; then A,B,C with pending stepping 111->110->100->000.
REQ-033 Backpressure: data_ready=0 for 5 cycles with A in HOLD -> data_out=A stable; data_ready=1 -> B next cycle.
REQ-034 Overrun (macro on): slot 1 full, pointer at 0, second core_done[1] with D -> overrun=1, slot 1 keeps B; flush -> overrun=0, pending=000.
REQ-035 Wrap and reset: 4 blocks through (pointer wraps to core 0 for block 4); assert rst while data_valid=1 -> data_valid=0, data_out=0 asynchronously.
